// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, parity mode encodings and a parity helper.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } rx_state_e;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_ODD  = 1;
    localparam int unsigned PARITY_EVEN = 2;

    // Reduction XOR over up to 9 data bits (narrower words are zero-extended by the caller).
    function automatic logic parity9(input logic [8:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every DIV clocks, free-running while enabled.
module uart_baud_tick #(
    parameter int unsigned DIV = 27
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (clear || !en) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(DIV - 1)) begin
            cnt_d = '0;
            tick  = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_frame.sv
// Oversampled UART receiver with configurable framing and a one-entry valid/ready output register.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1,
    parameter int unsigned OVS       = 16,
    parameter int unsigned DIV       = 27
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_en,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 perr_o,
    output logic                 ferr_o,
    output logic                 overrun_o,
    output logic                 busy_o
);

    localparam int unsigned OW = $clog2(OVS);
    localparam int unsigned BW = $clog2(DATA_BITS + 1);

    logic                 rx_meta_q, rx_s_q, rx_prev_q;
    logic                 tick;
    rx_state_e            state_q, state_d;
    logic [OW-1:0]        ovs_q, ovs_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 perr_acc_q, perr_acc_d;
    logic                 ferr_acc_q, ferr_acc_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 overrun_q, overrun_d;

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (rx_en),
        .clear (1'b0),
        .tick  (tick)
    );

    always_comb begin
        state_d    = state_q;
        ovs_d      = ovs_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        perr_acc_d = perr_acc_q;
        ferr_acc_d = ferr_acc_q;
        data_d     = data_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        overrun_d  = 1'b0;
        valid_d    = (valid_q && ready_i) ? 1'b0 : valid_q;

        if (!rx_en) begin
            state_d = S_IDLE;
            ovs_d   = '0;
            bit_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    // Edge detect needs a prior 1, so a held break cannot retrigger.
                    if (rx_prev_q && !rx_s_q) begin
                        state_d    = S_START;
                        ovs_d      = '0;
                        perr_acc_d = 1'b0;
                        ferr_acc_d = 1'b0;
                    end
                end
                S_START: begin
                    if (tick) begin
                        if (ovs_q == OW'(OVS / 2 - 1)) begin
                            ovs_d   = '0;
                            bit_d   = '0;
                            state_d = rx_s_q ? S_IDLE : S_DATA;
                        end else begin
                            ovs_d = ovs_q + 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        if (ovs_q == OW'(OVS - 1)) begin
                            ovs_d   = '0;
                            shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
                            if (bit_q == BW'(DATA_BITS - 1)) begin
                                bit_d   = '0;
                                state_d = (PARITY != PARITY_NONE) ? S_PARITY : S_STOP;
                            end else begin
                                bit_d = bit_q + 1'b1;
                            end
                        end else begin
                            ovs_d = ovs_q + 1'b1;
                        end
                    end
                end
                S_PARITY: begin
                    if (tick) begin
                        if (ovs_q == OW'(OVS - 1)) begin
                            ovs_d      = '0;
                            perr_acc_d = (parity9(9'(shift_q)) ^ rx_s_q) != (PARITY == PARITY_ODD);
                            state_d    = S_STOP;
                        end else begin
                            ovs_d = ovs_q + 1'b1;
                        end
                    end
                end
                S_STOP: begin
                    if (tick) begin
                        if (ovs_q == OW'(OVS - 1)) begin
                            ovs_d = '0;
                            if (!rx_s_q) begin
                                ferr_acc_d = 1'b1;
                            end
                            if (bit_q == BW'(STOP_BITS - 1)) begin
                                state_d = S_IDLE;
                                bit_d   = '0;
                                // Commit on the final stop sample; a consumer accept this cycle frees the slot.
                                if (!valid_q || ready_i) begin
                                    data_d  = shift_q;
                                    perr_d  = perr_acc_q;
                                    ferr_d  = ferr_acc_q | !rx_s_q;
                                    valid_d = 1'b1;
                                end else begin
                                    overrun_d = 1'b1;
                                end
                            end else begin
                                bit_d = bit_q + 1'b1;
                            end
                        end else begin
                            ovs_d = ovs_q + 1'b1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            rx_prev_q  <= 1'b1;
            state_q    <= S_IDLE;
            ovs_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            perr_acc_q <= 1'b0;
            ferr_acc_q <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            rx_meta_q  <= rx_in;
            rx_s_q     <= rx_meta_q;
            rx_prev_q  <= rx_s_q;
            state_q    <= state_d;
            ovs_q      <= ovs_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            perr_acc_q <= perr_acc_d;
            ferr_acc_q <= ferr_acc_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            overrun_q  <= overrun_d;
        end
    end

    assign data_o    = data_q;
    assign valid_o   = valid_q;
    assign perr_o    = perr_q;
    assign ferr_o    = ferr_q;
    assign overrun_o = overrun_q;
    assign busy_o    = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Scoreboard bench for uart_rx_frame: directed frames push expected results, a monitor checks deliveries.
module tb_uart_rx_frame;

    localparam int unsigned BIT = 32;  // OVS * DIV clocks per bit

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_en = 1'b1;
    logic       rx_in = 1'b1;
    logic [7:0] data_o;
    logic       valid_o;
    logic       ready_i = 1'b1;
    logic       perr_o, ferr_o, overrun_o, busy_o;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   n_ovr = 0;
    bit   chk_drop = 1'b0;

    uart_rx_frame #(
        .DATA_BITS (8),
        .PARITY    (2),
        .STOP_BITS (1),
        .OVS       (16),
        .DIV       (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_en     (rx_en),
        .rx_in     (rx_in),
        .data_o    (data_o),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .perr_o    (perr_o),
        .ferr_o    (ferr_o),
        .overrun_o (overrun_o),
        .busy_o    (busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        rx_in = b;
        clks(BIT);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                              input bit push, input logic eperr, input logic eferr);
        exp_t e;
        if (push) begin
            e.data = d;
            e.perr = eperr;
            e.ferr = eferr;
            exp_q.push_back(e);
        end
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(par);
        drive_bit(stp);
        drive_bit(1'b1);
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || valid_o) && k < 2000) begin
            clks(1);
            k++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (overrun_o) n_ovr++;
        if (chk_drop) begin
            chk_drop = 1'b0;
            chk("valid_drop", valid_o, 0);
        end
        if (valid_o && ready_i) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_valid: data_o=%0h with no frame expected", data_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("data", data_o, e.data);
                chk("perr", perr_o, e.perr);
                chk("ferr", ferr_o, e.ferr);
            end
            chk_drop = 1'b1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        clks(4);
        chk("rst_valid", valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_data", data_o, 0);
        chk("rst_perr", perr_o, 0);
        chk("rst_ferr", ferr_o, 0);
        chk("rst_overrun", overrun_o, 0);
        rst_n = 1'b1;
        clks(BIT);

        send_frame(8'hA5, 1'b0, 1'b1, 1, 1'b0, 1'b0);
        send_frame(8'h3C, 1'b1, 1'b1, 1, 1'b1, 1'b0);
        drain("drain_a");

        // Start-bit glitch: 6 ticks low, then idle.
        rx_in = 1'b0;
        clks(10);
        chk("glitch_busy_hi", busy_o, 1);
        clks(2);
        rx_in = 1'b1;
        clks(12);
        chk("glitch_busy_lo", busy_o, 0);
        chk("glitch_no_valid", valid_o, 0);
        clks(BIT);

        send_frame(8'h81, 1'b0, 1'b0, 1, 1'b0, 1'b1);
        send_frame(8'h7E, 1'b0, 1'b1, 1, 1'b0, 1'b0);
        drain("drain_b");

        ready_i = 1'b0;
        send_frame(8'h11, 1'b0, 1'b1, 1, 1'b0, 1'b0);
        send_frame(8'h22, 1'b0, 1'b1, 0, 1'b0, 1'b0);
        chk("ovr_data_kept", data_o, 8'h11);
        chk("ovr_valid_held", valid_o, 1);
        chk("ovr_count", n_ovr, 1);
        ready_i = 1'b1;
        drain("drain_c");

        // Reset mid-frame after four data bits.
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy_o, 0);
        chk("midrst_valid", valid_o, 0);
        clks(3);
        rx_in = 1'b1;
        rst_n = 1'b1;
        clks(2 * BIT);
        send_frame(8'h55, 1'b0, 1'b1, 1, 1'b0, 1'b0);
        drain("drain_d");

        // Receiver disable mid-frame after four data bits.
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(i[0]);
        rx_en = 1'b0;
        clks(2);
        chk("dis_busy", busy_o, 0);
        rx_in = 1'b1;
        clks(BIT);
        rx_en = 1'b1;
        clks(BIT);
        send_frame(8'h55, 1'b0, 1'b1, 1, 1'b0, 1'b0);
        drain("drain_e");
        chk("dis_data", data_o, 8'h55);
        chk("total_overruns", n_ovr, 1);

        clks(4);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
